raster_irq_gen: RTL and testbench

RASTER_IRQ_GEN -- requirements
Module: raster_irq_gen

---
 rtl/raster_irq_pkg.sv | 15 +
 rtl/raster_irq_gen_sync_edge.sv | 21 ++
 rtl/raster_irq_gen.sv | 77 +++++++
 tb/tb_raster_irq_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_irq_pkg.sv
// raster_irq_pkg: shared defaults, INT_SRC bit positions and a sizing helper for raster_irq_gen.
package raster_irq_pkg;
    localparam int DEF_CNT_W     = 6;
    localparam int DEF_LINE_DIV  = 52;
    localparam int DEF_VS_LINES  = 2;
    localparam int DEF_VS_THRESH = 32;
    localparam int DEF_LINE_W    = 8;
    localparam bit DEF_PRI_EXCL  = 1'b1;
    localparam int SRC_PER = 0;
    localparam int SRC_RAS = 1;
    // Countdown register width able to hold the VSYNC line delay.
    function automatic int cd_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/raster_irq_gen_sync_edge.sv
// sync_edge: two-flop synchroniser followed by a registered single-cycle edge pulse.
module sync_edge #(
    parameter bit FALL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    // sr[1:0] is the synchroniser, sr[2] holds the previous synchronised level.
    logic [2:0] sr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            pulse <= 1'b0;
        end else begin
            sr    <= {sr[1:0], din};
            pulse <= FALL ? (sr[2] & ~sr[1]) : (~sr[2] & sr[1]);
        end
    end
endmodule

// File: rtl/raster_irq_gen.sv
// raster_irq_gen: periodic and programmable-raster-line interrupt generator driven by CRTC sync pulses.
module raster_irq_gen
    import raster_irq_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LINE_DIV  = DEF_LINE_DIV,
    parameter int VS_LINES  = DEF_VS_LINES,
    parameter int VS_THRESH = DEF_VS_THRESH,
    parameter int LINE_W    = DEF_LINE_W,
    parameter bit PRI_EXCL  = DEF_PRI_EXCL
) (
    input  logic              CLK_n,
    input  logic              RESET,
    input  logic              HSYNC,
    input  logic              VSYNC,
    input  logic              IRQ_ACK,
    input  logic              IRQ_RESET,
    input  logic [LINE_W-1:0] PRI_LINE,
    output logic              INT_n,
    output logic [1:0]        INT_SRC,
    output logic [LINE_W-1:0] LINE_CNT,
    output logic              MODE_SYNC
);
    localparam int CD_W = cd_width(VS_LINES);
    localparam logic [CNT_W-1:0] DIV_TOP  = CNT_W'(LINE_DIV - 1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(VS_THRESH);
    localparam logic [CNT_W-1:0] MSB_KEEP = {1'b0, {(CNT_W - 1){1'b1}}};
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(VS_LINES);

    logic              tick, v_rise;
    logic [CNT_W-1:0]  cnt, cnt_tk, cnt_nx;
    logic [CD_W-1:0]   cd, cd_nx;
    logic [LINE_W-1:0] line_nx;
    logic [1:0]        pend, pend_nx;
    logic              supp, expire, wrap, line_inc, ack_ras, ack_per;

    sync_edge #(.FALL(1'b1)) u_hs (.clk(CLK_n), .rst(RESET), .din(HSYNC), .pulse(tick));
    sync_edge #(.FALL(1'b0)) u_vs (.clk(CLK_n), .rst(RESET), .din(VSYNC), .pulse(v_rise));

    // A VSYNC rise in the same cycle as a tick restarts the countdown, so that tick is not counted.
    always_comb begin
        supp     = PRI_EXCL && (PRI_LINE != '0);
        expire   = tick && !v_rise && (cd == CD_W'(1));
        wrap     = tick && !expire && (cnt == DIV_TOP);
        line_inc = tick && !v_rise && (LINE_CNT != '1);
        line_nx  = v_rise ? '0 : line_inc ? LINE_CNT + LINE_W'(1) : LINE_CNT;
        cd_nx    = v_rise ? CD_LOAD : (tick && cd != '0) ? cd - CD_W'(1) : cd;
        ack_ras  = IRQ_ACK && pend[SRC_RAS];
        ack_per  = IRQ_ACK && !pend[SRC_RAS] && pend[SRC_PER];
        cnt_tk   = (expire || wrap) ? '0 : tick ? cnt + CNT_W'(1) : cnt;
        cnt_nx   = IRQ_RESET ? '0 : ack_per ? (cnt_tk & MSB_KEEP) : cnt_tk;
        pend_nx  = '0;
        pend_nx[SRC_PER] = !IRQ_RESET &&
            ((!supp && ((expire && cnt >= THRESH) || wrap)) || (pend[SRC_PER] && !ack_per));
        pend_nx[SRC_RAS] = (line_inc && line_nx == PRI_LINE && PRI_LINE != '0) ||
            (pend[SRC_RAS] && !ack_ras);
    end

    always_ff @(posedge CLK_n or posedge RESET) begin
        if (RESET) begin
            cnt      <= '0;
            cd       <= '0;
            LINE_CNT <= '0;
            pend     <= '0;
            INT_n    <= 1'b1;
        end else begin
            cnt      <= cnt_nx;
            cd       <= cd_nx;
            LINE_CNT <= line_nx;
            pend     <= pend_nx;
            INT_n    <= ~|pend_nx;
        end
    end

    assign INT_SRC   = pend;
    assign MODE_SYNC = tick;
endmodule

// File: tb/tb_raster_irq_gen.sv
// tb_raster_irq_gen: random and directed stimulus on two configurations, scoreboarded against a line-level model.
module tb_raster_irq_gen;
    logic       clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0, ack = 1'b0, irqr = 1'b0;
    logic [8:0] pri = '0;
    logic       int_n0, int_n1, ms0, ms1;
    logic [1:0] src0, src1;
    logic [7:0] line0;
    logic [8:0] line1;

    always #5 clk = ~clk;

    raster_irq_gen u0 (
        .CLK_n(clk), .RESET(rst), .HSYNC(hs), .VSYNC(vs), .IRQ_ACK(ack), .IRQ_RESET(irqr),
        .PRI_LINE(pri[7:0]), .INT_n(int_n0), .INT_SRC(src0), .LINE_CNT(line0), .MODE_SYNC(ms0)
    );
    raster_irq_gen #(.CNT_W(7), .LINE_DIV(100), .LINE_W(9)) u1 (
        .CLK_n(clk), .RESET(rst), .HSYNC(hs), .VSYNC(vs), .IRQ_ACK(ack), .IRQ_RESET(irqr),
        .PRI_LINE(pri), .INT_n(int_n1), .INT_SRC(src1), .LINE_CNT(line1), .MODE_SYNC(ms1)
    );

    typedef struct { int cnt; int cd; int line; bit per; bit ras; } mst_t;
    typedef struct { int int_n0; int src0; int line0; int int_n1; int src1; int line1; string tag; } exp_t;

    mst_t m[2];
    int   div[2]  = '{52, 100};
    int   lmax[2] = '{255, 511};
    int   msb[2]  = '{32, 64};
    exp_t q[$];
    int   total = 0, bad = 0;
    bit   smp = 1'b0;

    task automatic chk(input string t, input string f, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s %s actual=%0d required=%0d", t, f, act, req);
        end
    endtask

    // Line-level model: one call per scanline, counting in plain integers.
    function automatic mst_t mdl_tick(input mst_t s, input int k, input int p, input bit clr);
        bit ex = (s.cd == 1);
        if (s.line < lmax[k]) begin
            s.line++;
            if (p != 0 && s.line == p) s.ras = 1'b1;
        end
        if (s.cd > 0) s.cd--;
        if (clr) begin
            s.cnt = 0;
            s.per = 1'b0;
        end else if (ex) begin
            if (s.cnt >= 32 && p == 0) s.per = 1'b1;
            s.cnt = 0;
        end else if (s.cnt == div[k] - 1) begin
            s.cnt = 0;
            if (p == 0) s.per = 1'b1;
        end else s.cnt++;
        return s;
    endfunction

    function automatic mst_t mdl_ack(input mst_t s, input int k);
        if (s.ras) s.ras = 1'b0;
        else if (s.per) begin
            s.per = 1'b0;
            s.cnt = s.cnt % msb[k];
        end
        return s;
    endfunction

    task automatic push(input string t);
        exp_t e;
        e.int_n0 = (m[0].per || m[0].ras) ? 0 : 1;
        e.src0   = 2 * int'(m[0].ras) + int'(m[0].per);
        e.line0  = m[0].line;
        e.int_n1 = (m[1].per || m[1].ras) ? 0 : 1;
        e.src1   = 2 * int'(m[1].ras) + int'(m[1].per);
        e.line1  = m[1].line;
        e.tag    = t;
        q.push_back(e);
        smp = 1'b1;
        @(negedge clk);
        smp = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (smp) begin
                if (q.size() == 0) chk("scoreboard", "queue_depth", 0, 1);
                else begin
                    e = q.pop_front();
                    chk(e.tag, "int_n0", int'(int_n0), e.int_n0);
                    chk(e.tag, "src0", int'(src0), e.src0);
                    chk(e.tag, "line0", int'(line0), e.line0);
                    chk(e.tag, "int_n1", int'(int_n1), e.int_n1);
                    chk(e.tag, "src1", int'(src1), e.src1);
                    chk(e.tag, "line1", int'(line1), e.line1);
                end
            end
        end
    end

    // One HSYNC pulse; clr raises IRQ_RESET exactly in the cycle the tick is consumed.
    task automatic do_tick(input bit clr, input string t);
        int n = 0;
        hs = 1'b1;
        repeat (4) @(negedge clk);
        hs = 1'b0;
        while (!ms0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk(t, "tick_latency", n, 3);
        chk(t, "mode_sync1", int'(ms1), 1);
        if (clr) irqr = 1'b1;
        @(negedge clk);
        irqr = 1'b0;
        for (int k = 0; k < 2; k++) m[k] = mdl_tick(m[k], k, int'(pri), clr);
        push(t);
    endtask

    task automatic do_vsync(input string t);
        vs = 1'b1;
        repeat (6) @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m[k].line = 0;
            m[k].cd   = 2;
        end
        push(t);
    endtask

    task automatic do_ack(input string t);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        for (int k = 0; k < 2; k++) m[k] = mdl_ack(m[k], k);
        push(t);
    endtask

    task automatic do_irqr(input string t);
        irqr = 1'b1;
        repeat (2) @(negedge clk);
        irqr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m[k].cnt = 0;
            m[k].per = 1'b0;
        end
        push(t);
    endtask

    task automatic set_pri(input int v, input string t);
        pri = 9'(v);
        repeat (2) @(negedge clk);
        push(t);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) m[k] = '{cnt: 0, cd: 0, line: 0, per: 1'b0, ras: 1'b0};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        chk("por", "mode_sync0", int'(ms0), 0);
        push("por");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 1; i <= 104; i++) begin
            do_tick(1'b0, "periodic");
            if (i == 52) do_ack("ack_at_52");
        end
        do_ack("ack_at_104");

        do_vsync("vs_a");
        repeat (2) do_tick(1'b0, "vs_a_tick");
        repeat (2) do_ack("vs_a_ack");
        repeat (40) do_tick(1'b0, "to40");
        do_vsync("vs_40");
        repeat (2) do_tick(1'b0, "vs_40_tick");
        do_ack("vs_40_ack");
        repeat (20) do_tick(1'b0, "to20");
        do_vsync("vs_20");
        repeat (2) do_tick(1'b0, "vs_20_tick");

        set_pri(100, "pri100");
        do_vsync("vs_pri");
        repeat (100) do_tick(1'b0, "raster");
        do_ack("raster_ack");
        set_pri(0, "pri0");

        do_vsync("vs_both");
        for (int i = 0; i < 60 && !m[0].per; i++) do_tick(1'b0, "to_per");
        set_pri(m[0].line + 1, "pri_next");
        do_tick(1'b0, "both_pending");
        do_ack("ack_first");
        do_ack("ack_second");
        set_pri(0, "pri0b");
        repeat (43) do_tick(1'b0, "after_msb_clear");

        do_vsync("vs_c");
        repeat (2) do_tick(1'b0, "vs_c_tick");
        repeat (2) do_ack("vs_c_ack");
        while (m[0].cnt != 51) do_tick(1'b0, "to51");
        do_tick(1'b1, "irqr_coincident");
        do_irqr("irqr_level");
        do_tick(1'b0, "after_irqr");

        do_vsync("vs_rst");
        do_tick(1'b0, "countdown");
        #2 rst = 1'b1;
        #1;
        chk("async_rst", "int_n0", int'(int_n0), 1);
        chk("async_rst", "line0", int'(line0), 0);
        clear_model();
        @(negedge clk);
        push("in_reset");
        rst = 1'b0;
        @(negedge clk);
        repeat (52) do_tick(1'b0, "post_reset");
        do_ack("post_reset_ack");

        for (int i = 0; i < 520; i++) begin
            do_tick(1'b0, "saturate");
            if (m[0].per || m[0].ras || m[1].per || m[1].ras) do_ack("sat_ack");
        end

        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 55) do_tick($urandom_range(0, 19) == 0, "rnd_tick");
            else if (r < 65) do_vsync("rnd_vsync");
            else if (r < 80) do_ack("rnd_ack");
            else if (r < 88) do_irqr("rnd_irqr");
            else begin
                int v = ($urandom_range(0, 3) == 0) ? 0 : m[0].line + int'($urandom_range(1, 20));
                set_pri((v > 255) ? 255 : v, "rnd_pri");
            end
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("scoreboard", "leftover", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
